// File: rtl/riscv_defs.sv
// Shared RV32I definitions: format codes, opcodes, encoder FSM states.
// Format codes match the control decoder's imm_src encoding.
package riscv_defs;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } enc_state_t;

    function automatic logic [7:0] word_byte(
        input logic [31:0] w,
        input logic [1:0]  idx
    );
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with illegal-format and
// odd-offset indications for the encoder's check logic.
module instr_pack
    import riscv_defs::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  f3,
    input  logic [6:0]  f7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal,
    output logic        misalign
);

    // Select the bit layout for the requested format
    always_comb begin
        word = {f7, rs2, rs1, f3, rd, opcode};
        illegal = 1'b0;
        case (fmt)
            FMT_R: word = {f7, rs2, rs1, f3, rd, opcode};
            FMT_I: word = {imm[11:0], rs1, f3, rd, opcode};
            FMT_S: word = {imm[11:5], rs2, rs1, f3,
                           imm[4:0], opcode};
            FMT_B: word = {imm[12], imm[10:5], rs2, rs1, f3,
                           imm[4:1], imm[11], opcode};
            FMT_U: word = {imm[31:12], rd, opcode};
            FMT_J: word = {imm[20], imm[10:1], imm[11],
                           imm[19:12], rd, opcode};
            default: begin
                word = {f7, rs2, rs1, f3, rd, opcode};
                illegal = 1'b1;
            end
        endcase
    end

    // Branch and jump offsets are halfword units; bit 0 is lost
    assign misalign = ((fmt == FMT_B) || (fmt == FMT_J)) && imm[0];

endmodule

// File: rtl/instr_encoder.sv
// Byte-serial RV32I encoder writing packed words little-endian.
// Optional INSTR_ENCODER_CHECK_EN drops illegal formats and flags errors.
module instr_encoder
    import riscv_defs::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        f3,
    input  logic [6:0]        f7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W-1:0] instr_count,
    output logic              error
);

    localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    enc_state_t  state;
    enc_state_t  state_nxt;
    logic [1:0]  byte_cnt;
    logic [1:0]  cnt_nxt;
    logic [31:0] word;
    logic [31:0] pk_word;
    logic        illegal;
    logic        misalign;
    logic        accept;
    logic        drop;
    logic        load;
    logic        last_byte;

    instr_pack u_pack (
        .fmt      (fmt),
        .opcode   (opcode),
        .f3       (f3),
        .f7       (f7),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .imm      (imm),
        .word     (pk_word),
        .illegal  (illegal),
        .misalign (misalign)
    );

    assign last_byte = (state == ST_WRITE) && (byte_cnt == 2'd3);
    assign in_ready  = (state == ST_IDLE) || last_byte;
    assign accept    = in_valid && in_ready;
    assign load      = accept && !drop;
    assign cnt_nxt   = byte_cnt + 2'd1;

`ifdef INSTR_ENCODER_CHECK_EN
    assign drop = illegal;

    // Sticky error on illegal format or odd branch/jump offset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error <= 1'b0;
        end else if (clear) begin
            error <= 1'b0;
        end else if (accept && (illegal || misalign)) begin
            error <= 1'b1;
        end
    end
`else
    logic unused_chk;

    assign drop       = 1'b0;
    assign error      = 1'b0;
    assign unused_chk = illegal | misalign;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: stay writing while words keep arriving
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (last_byte && !load) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (clear) begin
            state_nxt = ST_IDLE;
        end
    end

    // Byte sequencing, registered write port and word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt    <= 2'd0;
            word        <= 32'd0;
            mem_we      <= 1'b0;
            mem_addr    <= BASE;
            mem_wdata   <= 8'd0;
            instr_count <= '0;
        end else if (clear) begin
            byte_cnt    <= 2'd0;
            mem_we      <= 1'b0;
            mem_addr    <= BASE;
            instr_count <= '0;
        end else begin
            if (state == ST_WRITE) begin
                mem_addr <= mem_addr + ONE;
            end
            if (last_byte) begin
                instr_count <= instr_count + ONE;
            end
            if (load) begin
                word      <= pk_word;
                byte_cnt  <= 2'd0;
                mem_we    <= 1'b1;
                mem_wdata <= pk_word[7:0];
            end else if ((state == ST_WRITE) && !last_byte) begin
                byte_cnt  <= cnt_nxt;
                mem_we    <= 1'b1;
                mem_wdata <= word_byte(word, cnt_nxt);
            end else begin
                byte_cnt <= 2'd0;
                mem_we   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder (ADDR_W 8 and ADDR_W 4 instances).
// Expectations follow INSTR_ENCODER_CHECK_EN when it is defined.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;

    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  instr_count;
    logic        error;

    logic        in_ready2;
    logic        mem_we2;
    logic [3:0]  mem_addr2;
    logic [7:0]  mem_wdata2;
    logic [3:0]  instr_count2;
    logic        error2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] qa[$];
    logic [7:0] qd[$];
    int         qc[$];
    logic [3:0] wa[$];

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .f3(f3), .f7(f7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .instr_count(instr_count),
        .error(error)
    );

    instr_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready2),
        .fmt(fmt), .opcode(opcode), .f3(f3), .f7(f7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .instr_count(instr_count2),
        .error(error2)
    );

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            qa.push_back(mem_addr);
            qd.push_back(mem_wdata);
            qc.push_back(cyc);
        end
        if (mem_we2) wa.push_back(mem_addr2);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1);
    end

    task automatic flush();
        qa.delete();
        qd.delete();
        qc.delete();
        wa.delete();
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op,
                        input logic [2:0] fn3, input logic [6:0] fn7,
                        input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im);
        int n = 0;
        fmt = f; opcode = op; f3 = fn3; f7 = fn7;
        rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (!in_ready) begin
            fails++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        imm = 32'hDEAD_BEEF;
        rd = 5'h1F;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(in_ready && !mem_we) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (!(in_ready && !mem_we)) begin
            fails++;
            $display("FAIL wait_idle: timeout in_ready=%b mem_we=%b",
                     in_ready, mem_we);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        flush();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        fmt = 0; opcode = 0; f3 = 0; f7 = 0;
        rd = 0; rs1 = 0; rs2 = 0; imm = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL rst_in_ready: got %b want 1", in_ready);
        end
        tests++;
        if (mem_we !== 1'b0) begin
            fails++; $display("FAIL rst_mem_we: got %b want 0", mem_we);
        end
        tests++;
        if (mem_addr !== 8'd0) begin
            fails++; $display("FAIL rst_addr: got %h want 00", mem_addr);
        end
        tests++;
        if (mem_wdata !== 8'd0) begin
            fails++; $display("FAIL rst_wdata: got %h want 00", mem_wdata);
        end
        tests++;
        if (instr_count !== 8'd0) begin
            fails++; $display("FAIL rst_count: got %0d want 0", instr_count);
        end
        tests++;
        if (error !== 1'b0) begin
            fails++; $display("FAIL rst_error: got %b want 0", error);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w[2];
        logic [31:0] w;
        exp_w[0] = 32'h0050_0093;
        exp_w[1] = 32'h0020_81B3;
        flush();
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        wait_idle();
        tests++;
        if (qa.size() != 8) begin
            fails++; $display("FAIL b2b_nbytes: got %0d want 8", qa.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                w = {qd[4*k+3], qd[4*k+2], qd[4*k+1], qd[4*k]};
                tests++;
                if (w !== exp_w[k]) begin
                    fails++;
                    $display("FAIL b2b_word%0d: got %h want %h", k, w, exp_w[k]);
                end
            end
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (qa[i] !== 8'(i)) begin
                    fails++;
                    $display("FAIL b2b_addr%0d: got %0d want %0d", i, qa[i], i);
                end
            end
            tests++;
            if (qc[7] - qc[0] != 7) begin
                fails++;
                $display("FAIL b2b_gap: span %0d want 7", qc[7] - qc[0]);
            end
        end
        tests++;
        if (instr_count !== 8'd2) begin
            fails++; $display("FAIL b2b_count: got %0d want 2", instr_count);
        end
    endtask

    task automatic test_branch_jump();
        logic [31:0] exp_w[2];
        logic [31:0] w;
        exp_w[0] = 32'hFE20_8EE3;
        exp_w[1] = 32'h0080_00EF;
        pulse_clear();
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
        wait_idle();
        tests++;
        if (qa.size() != 8) begin
            fails++; $display("FAIL bj_nbytes: got %0d want 8", qa.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                w = {qd[4*k+3], qd[4*k+2], qd[4*k+1], qd[4*k]};
                tests++;
                if (w !== exp_w[k]) begin
                    fails++;
                    $display("FAIL bj_word%0d: got %h want %h", k, w, exp_w[k]);
                end
            end
            tests++;
            if (qa[0] !== 8'd0 || qa[7] !== 8'd7) begin
                fails++;
                $display("FAIL bj_addr: got %0d..%0d want 0..7", qa[0], qa[7]);
            end
        end
        tests++;
        if (instr_count !== 8'd2 || error !== 1'b0) begin
            fails++;
            $display("FAIL bj_status: count %0d err %b want 2 0",
                     instr_count, error);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] w;
        int          exp_n;
        logic [7:0]  exp_cnt;
        logic        exp_err;
`ifdef INSTR_ENCODER_CHECK_EN
        exp_n = 0; exp_cnt = 8'd0; exp_err = 1'b1;
`else
        exp_n = 4; exp_cnt = 8'd1; exp_err = 1'b0;
`endif
        pulse_clear();
        send(3'd6, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        wait_idle();
        tests++;
        if (qa.size() != exp_n) begin
            fails++;
            $display("FAIL ill_nbytes: got %0d want %0d", qa.size(), exp_n);
        end else if (exp_n == 4) begin
            w = {qd[3], qd[2], qd[1], qd[0]};
            tests++;
            if (w !== 32'h0020_81B3) begin
                fails++; $display("FAIL ill_word: got %h want 002081b3", w);
            end
        end
        tests++;
        if (mem_addr !== 8'(exp_n)) begin
            fails++;
            $display("FAIL ill_addr: got %0d want %0d", mem_addr, exp_n);
        end
        tests++;
        if (error !== exp_err || instr_count !== exp_cnt) begin
            fails++;
            $display("FAIL ill_status: err %b cnt %0d want %b %0d",
                     error, instr_count, exp_err, exp_cnt);
        end
        pulse_clear();
        tests++;
        if (error !== 1'b0 || instr_count !== 8'd0 || mem_addr !== 8'd0) begin
            fails++;
            $display("FAIL clr_status: err %b cnt %0d addr %0d want 0 0 0",
                     error, instr_count, mem_addr);
        end
        send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd9);
        wait_idle();
        tests++;
        if (qa.size() != 4) begin
            fails++; $display("FAIL odd_nbytes: got %0d want 4", qa.size());
        end else begin
            w = {qd[3], qd[2], qd[1], qd[0]};
            tests++;
            if (w !== 32'h0080_00EF) begin
                fails++; $display("FAIL odd_word: got %h want 008000ef", w);
            end
        end
        tests++;
        if (error !== exp_err) begin
            fails++; $display("FAIL odd_error: got %b want %b", error, exp_err);
        end
    endtask

    task automatic test_clear_priority();
        pulse_clear();
        fmt = 3'd1; opcode = 7'h13; f3 = 0; f7 = 0;
        rd = 5'd1; rs1 = 0; rs2 = 0; imm = 32'd5;
        in_valid = 1'b1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (qa.size() != 0 || instr_count !== 8'd0 || mem_addr !== 8'd0) begin
            fails++;
            $display("FAIL clr_prio: bytes %0d cnt %0d addr %0d want 0 0 0",
                     qa.size(), instr_count, mem_addr);
        end
    endtask

    task automatic test_wrap();
        pulse_clear();
        for (int i = 0; i < 5; i++) begin
            send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        end
        wait_idle();
        tests++;
        if (wa.size() != 20) begin
            fails++; $display("FAIL wrap_nbytes: got %0d want 20", wa.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (wa[16+i] !== 4'(i)) begin
                    fails++;
                    $display("FAIL wrap_addr%0d: got %0d want %0d",
                             i, wa[16+i], i);
                end
            end
        end
        tests++;
        if (instr_count2 !== 4'd5 || mem_addr2 !== 4'd4) begin
            fails++;
            $display("FAIL wrap_status: cnt %0d addr %0d want 5 4",
                     instr_count2, mem_addr2);
        end
        tests++;
        if (mem_addr !== 8'd20 || instr_count !== 8'd5) begin
            fails++;
            $display("FAIL nowrap_status: addr %0d cnt %0d want 20 5",
                     mem_addr, instr_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        pulse_clear();
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(posedge clk); #1;
        tests++;
        if (mem_we !== 1'b1 || mem_addr !== 8'd1) begin
            fails++;
            $display("FAIL mid_byte1: we %b addr %0d want 1 1", mem_we, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (mem_we !== 1'b0 || mem_addr !== 8'd0 || mem_wdata !== 8'd0 ||
            instr_count !== 8'd0 || in_ready !== 1'b1 || error !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst: we %b addr %0d wd %h cnt %0d rdy %b err %b",
                     mem_we, mem_addr, mem_wdata, instr_count, in_ready, error);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (qa.size() != 1) begin
            fails++; $display("FAIL mid_strobes: got %0d want 1", qa.size());
        end
        flush();
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        wait_idle();
        tests++;
        if (qa.size() != 4) begin
            fails++; $display("FAIL mid_nbytes: got %0d want 4", qa.size());
        end else begin
            w = {qd[3], qd[2], qd[1], qd[0]};
            tests++;
            if (w !== 32'h0050_0093 || qa[0] !== 8'd0 || qa[3] !== 8'd3) begin
                fails++;
                $display("FAIL mid_reload: word %h addr %0d..%0d want 00500093 0..3",
                         w, qa[0], qa[3]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_branch_jump();
        test_illegal();
        test_clear_priority();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
